// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources.
// Each source owns a small FIFO. A round-robin scheduler drains the FIFOs into
// the UART one byte at a time and paces itself on txBusy.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int DEPTH_LOG2   = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]   reqWr,
    output logic [NUM_REQ-1:0]   reqFull,
    output logic [NUM_REQ-1:0]   ovfFlag,
    input  logic                 clrOvf,
    output logic [7:0]           txData,
    output logic                 txDataWr,
    input  logic                 txBusy,
    output logic [ID_W-1:0]      grantId,
    output logic                 arbBusy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Per-requester FIFO storage and bookkeeping
    logic [7:0]            mem       [NUM_REQ][DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr    [NUM_REQ];
    logic [DEPTH_LOG2-1:0] rd_ptr    [NUM_REQ];
    logic [CNT_W-1:0]      count     [NUM_REQ];
    logic [CNT_W-1:0]      count_nxt [NUM_REQ];
    logic [NUM_REQ-1:0]    not_empty;
    logic [NUM_REQ-1:0]    push;
    logic [NUM_REQ-1:0]    pop;
    logic [NUM_REQ-1:0]    drop;
    logic [7:0]            pop_data;

    // Scheduler state
    state_t                state;
    state_t                state_nxt;
    logic [TMR_W-1:0]      timer;
    logic [TMR_W-1:0]      timer_nxt;
    logic [ID_W-1:0]       last_grant;
    logic [ID_W-1:0]       pick;
    logic                  pick_valid;
    logic                  grant;
    int                    rr_dist;
    int                    rr_best;

    // Occupancy flags derived from the registered counts
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        not_empty = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            not_empty[i] = (count[i] != '0);
        end
    end

    // Round-robin search: the non-empty FIFO closest after last_grant wins
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        rr_best    = NUM_REQ;
        rr_dist    = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rr_dist = (j + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            if (not_empty[j] && (rr_dist < rr_best)) begin
                rr_best    = rr_dist;
                pick       = ID_W'(j);
                pick_valid = 1'b1;
            end
        end
    end

    // A byte is taken only from IDLE while the UART is free
    assign grant = (state == IDLE) && pick_valid && !txBusy;

    // Push/pop/drop decisions, next counts, and the head byte of the granted FIFO
    always_comb begin
        pop      = '0;
        push     = '0;
        drop     = '0;
        pop_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i]       = grant && (pick == ID_W'(i));
            // A full FIFO still takes a push when it is popped in the same cycle.
            push[i]      = reqWr[i] && (!reqFull[i] || pop[i]);
            drop[i]      = reqWr[i] && !push[i];
            count_nxt[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            if (pop[i]) begin
                pop_data = mem[i][rd_ptr[i]];
            end
        end
    end

    // FIFO storage write port
    // NOTE: the data array carries no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= reqData[8*i +: 8];
            end
        end
    end

    // FIFO pointers, counts and the registered full flags
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            reqFull <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i]   <= count_nxt[i];
                reqFull[i] <= (count_nxt[i] == CNT_W'(DEPTH));
            end
        end
    end

    // Sticky overflow flags; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfFlag <= '0;
        end else begin
            ovfFlag <= (clrOvf ? '0 : ovfFlag) | drop;
        end
    end

    // Scheduler next-state logic and strobe/busy outputs
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        txDataWr  = 1'b0;
        arbBusy   = 1'b1;
        case (state)
            IDLE: begin
                arbBusy = 1'b0;
                if (grant) state_nxt = SEND;
            end
            SEND: begin
                txDataWr  = 1'b1;
                timer_nxt = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (txBusy) begin
                    state_nxt = WAIT_DONE;
                end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    // UART never acknowledged: treat the byte as sent and move on.
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!txBusy) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Scheduler registers; txData and grantId hold until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            txData     <= '0;
            grantId    <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (grant) begin
                last_grant <= pick;
                grantId    <= pick;
                txData     <= pop_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// batches, with a queue-based round-robin reference model and a strobe monitor.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int DEPTH        = 4;
    localparam int BUSY_TIMEOUT = 4;

    logic                 clk;
    logic                 rst_n;
    logic [8*NUM_REQ-1:0] reqData;
    logic [NUM_REQ-1:0]   reqWr;
    logic [NUM_REQ-1:0]   reqFull;
    logic [NUM_REQ-1:0]   ovfFlag;
    logic                 clrOvf;
    logic [7:0]           txData;
    logic                 txDataWr;
    logic                 txBusy;
    logic [ID_W-1:0]      grantId;
    logic                 arbBusy;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .DEPTH_LOG2  (2),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .reqData (reqData),
        .reqWr   (reqWr),
        .reqFull (reqFull),
        .ovfFlag (ovfFlag),
        .clrOvf  (clrOvf),
        .txData  (txData),
        .txDataWr(txDataWr),
        .txBusy  (txBusy),
        .grantId (grantId),
        .arbBusy (arbBusy)
    );

    // Reference model: accepted bytes per requester, round-robin pointer, overflow flags
    logic [7:0]         exp_q [NUM_REQ][$];
    int                 m_last;
    logic [NUM_REQ-1:0] m_ovf;
    logic [7:0]         out_log[$];
    int                 gnt_log[$];

    int total   = 0;
    int bad     = 0;
    int strobes = 0;
    int mon_pick;

    logic hold;
    logic uart_busy;
    logic uart_en;
    int   frame;
    int   uart_cnt;

    assign txBusy = uart_busy | hold;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
        m_last = NUM_REQ - 1;
        m_ovf  = '0;
    endtask

    function automatic int exp_total();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += exp_q[i].size();
        return s;
    endfunction

    function automatic logic [NUM_REQ-1:0] model_full();
        logic [NUM_REQ-1:0] r = '0;
        for (int i = 0; i < NUM_REQ; i++) r[i] = (exp_q[i].size() == DEPTH);
        return r;
    endfunction

    // UART model: a strobe starts a frame of 'frame' cycles unless disabled
    initial begin
        uart_busy = 1'b0;
        uart_cnt  = 0;
        forever begin
            @(negedge clk);
            if (uart_cnt > 0) uart_cnt--;
            if (rst_n === 1'b1 && txDataWr === 1'b1 && uart_en) uart_cnt = frame;
            uart_busy = (uart_cnt > 0);
        end
    end

    // Monitor: every strobe must carry the model's next round-robin byte
    always @(negedge clk) begin
        if (rst_n === 1'b1 && txDataWr === 1'b1) begin
            strobes++;
            mon_pick = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (mon_pick < 0 && exp_q[(m_last + k) % NUM_REQ].size() > 0)
                    mon_pick = (m_last + k) % NUM_REQ;
            end
            out_log.push_back(txData);
            gnt_log.push_back(int'(grantId));
            if (mon_pick < 0) begin
                check("unexpected_strobe", 32'(exp_total()), 32'd1);
            end else begin
                m_last = mon_pick;
                check("sb_grant", 32'(grantId), 32'(mon_pick));
                check("sb_data", 32'(txData), 32'(exp_q[mon_pick].pop_front()));
            end
        end
    end

    // Drive one cycle of pushes (and optional clrOvf); cap=1 applies the model's capacity rule
    task automatic push_cycle(input logic [NUM_REQ-1:0] wr, input logic [8*NUM_REQ-1:0] d,
                              input bit clr, input bit cap);
        reqWr   = wr;
        reqData = d;
        clrOvf  = clr;
        if (clr) m_ovf = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr[i]) begin
                if (!cap || exp_q[i].size() < DEPTH) exp_q[i].push_back(d[8*i +: 8]);
                else m_ovf[i] = 1'b1;
            end
        end
        @(negedge clk);
        reqWr  = '0;
        clrOvf = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!arbBusy && exp_total() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_drain"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_strobe(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (txDataWr) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_strobe_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int base;
        int sb;
        int pos;
        logic [7:0] b;

        rst_n   = 1'b0;
        reqWr   = '0;
        reqData = '0;
        clrOvf  = 1'b0;
        hold    = 1'b0;
        uart_en = 1'b1;
        frame   = 10;
        model_clear();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_txDataWr", 32'(txDataWr), 32'd0);
        check("rst_txData",   32'(txData),   32'd0);
        check("rst_grantId",  32'(grantId),  32'd0);
        check("rst_arbBusy",  32'(arbBusy),  32'd0);
        check("rst_reqFull",  32'(reqFull),  32'd0);
        check("rst_ovfFlag",  32'(ovfFlag),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single byte, strobe exactly two cycles after the push
        push_cycle(4'b0001, 32'h0000_0041, 1'b0, 1'b1);
        check("t1_no_early_wr", 32'(txDataWr), 32'd0);
        @(negedge clk);
        check("t1_wr",   32'(txDataWr), 32'd1);
        check("t1_data", 32'(txData),   32'h41);
        check("t1_gid",  32'(grantId),  32'd0);
        @(negedge clk);
        check("t1_one_cycle", 32'(txDataWr), 32'd0);
        wait_drain("t1");

        // 2: simultaneous pushes after reset leave in index order
        do_reset();
        frame = 10;
        base  = out_log.size();
        sb    = strobes;
        push_cycle(4'b1111, 32'h1312_1110, 1'b0, 1'b1);
        wait_drain("t2");
        check("t2_strobes", 32'(strobes - sb), 32'd4);
        check("t2_count", 32'(out_log.size() - base), 32'd4);
        if (out_log.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) check("t2_order", 32'(out_log[base + k]), 32'(8'h10 + k));
        end

        // 3: fill req2 with the UART held busy, overflow, clear
        hold = 1'b1;
        sb   = strobes;
        for (int k = 0; k < 4; k++) push_cycle(4'b0100, 32'(8'h30 + k) << 16, 1'b0, 1'b1);
        check("t3_full_after4", 32'(reqFull[2]), 32'd1);
        check("t3_no_ovf_yet",  32'(ovfFlag[2]), 32'd0);
        push_cycle(4'b0100, 32'h0034_0000, 1'b0, 1'b1);
        check("t3_ovf_set",   32'(ovfFlag), 32'(m_ovf));
        check("t3_ovf2",      32'(ovfFlag[2]), 32'd1);
        check("t3_still_full", 32'(reqFull), 32'b0100);
        push_cycle(4'b0100, 32'h0035_0000, 1'b1, 1'b1);
        check("t3_set_wins", 32'(ovfFlag[2]), 32'd1);
        push_cycle(4'b0000, 32'h0, 1'b1, 1'b1);
        check("t3_cleared", 32'(ovfFlag), 32'd0);
        hold = 1'b0;
        wait_drain("t3");
        check("t3_strobes", 32'(strobes - sb), 32'd4);

        // 4: req1 streams continuously while req3 has one byte pending
        hold = 1'b1;
        push_cycle(4'b1010, 32'h3A00_1A00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) push_cycle(4'b0010, 32'(8'h1B + k) << 8, 1'b0, 1'b1);
        hold = 1'b0;
        base = gnt_log.size();
        for (int c = 0; c < 60; c++) begin
            if (!reqFull[1]) begin
                b = 8'($urandom);
                push_cycle(4'b0010, {16'h0, b, 8'h0}, 1'b0, 1'b0);
            end else begin
                @(negedge clk);
            end
        end
        wait_drain("t4");
        pos = -1;
        for (int k = base; k < gnt_log.size(); k++) if (pos < 0 && gnt_log[k] == 3) pos = k - base;
        check("t4_req3_by_second", 32'(pos >= 0 && pos <= 1), 32'd1);

        // 5: UART never raises busy; timeout returns to IDLE and the next byte still goes
        uart_en = 1'b0;
        hold    = 1'b1;
        push_cycle(4'b0001, 32'h0000_0050, 1'b0, 1'b1);
        push_cycle(4'b0001, 32'h0000_0051, 1'b0, 1'b1);
        hold = 1'b0;
        wait_strobe("t5_first");
        for (int k = 1; k <= BUSY_TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k == BUSY_TIMEOUT) check("t5_still_waiting", 32'(arbBusy), 32'd1);
            if (k == BUSY_TIMEOUT + 1) check("t5_back_idle", 32'(arbBusy), 32'd0);
        end
        @(negedge clk);
        check("t5_next_byte", 32'(txDataWr), 32'd1);
        wait_drain("t5");
        uart_en = 1'b1;

        // Randomized batches: fill with UART held off, compare flags, then drain
        for (int r = 0; r < 25; r++) begin
            hold    = 1'b1;
            frame   = $urandom_range(1, 12);
            uart_en = ($urandom_range(0, 4) != 0);
            for (int c = 0; c < $urandom_range(2, 10); c++) begin
                push_cycle(NUM_REQ'($urandom), $urandom, ($urandom_range(0, 7) == 0), 1'b1);
            end
            check("rnd_full", 32'(reqFull), 32'(model_full()));
            check("rnd_ovf",  32'(ovfFlag), 32'(m_ovf));
            if ($urandom_range(0, 1) == 1) begin
                push_cycle('0, '0, 1'b1, 1'b1);
                check("rnd_ovf_clr", 32'(ovfFlag), 32'd0);
            end
            hold = 1'b0;
            wait_drain("rnd");
            check("rnd_empty_full", 32'(reqFull), 32'd0);
        end
        uart_en = 1'b1;

        // 6: reset during WAIT_DONE with bytes queued
        frame = 30;
        push_cycle(4'b0111, 32'h0062_6160, 1'b0, 1'b1);
        wait_strobe("t6");
        repeat (5) @(negedge clk);
        check("t6_in_flight", 32'(arbBusy), 32'd1);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("t6_txDataWr", 32'(txDataWr), 32'd0);
        check("t6_txData",   32'(txData),   32'd0);
        check("t6_grantId",  32'(grantId),  32'd0);
        check("t6_arbBusy",  32'(arbBusy),  32'd0);
        check("t6_reqFull",  32'(reqFull),  32'd0);
        check("t6_ovfFlag",  32'(ovfFlag),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb = strobes;
        repeat (40) @(negedge clk);
        check("t6_no_strobe", 32'(strobes - sb), 32'd0);
        check("t6_idle",      32'(arbBusy),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
